grf_bank: RTL and testbench
===========================

Name: grf_bank

Overview:
- General register file for the single-cycle MIPS datapath.
- It is the consumer of the write-back path: the write-address select (rt/rd/$31) and write-data select (ALU/Mem/PC+4) drive its write port.
- It supplies rs/rt operands to the ALU-source select, the branch comparator and the jr target.
- 32 x 32-bit storage, two combinational read ports, one synchronous write port, $0 hardwired to zero, optional write-to-read bypass.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored value only.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ra1  input  ADDR_W  read address port 1 (rs).
- ra2  input  ADDR_W  read address port 2 (rt).
- rd1  output  DATA_W  read data port 1.
- rd2  output  DATA_W  read data port 2.
- we  input  1  write enable (RegWrite).
- wa  input  ADDR_W  write address, from write-address select.
- wd  input  DATA_W  write data, from write-data select.
- pc  input  32  PC of the instruction performing the write; used only by the trace feature.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset:
  - reset_n low immediately clears registers 1..2**ADDR_W-1 to 0, independent of clk.
  - While reset_n is low, rd1 = rd2 = 0 and writes are ignored.
  - Reset deasserting mid-cycle has no effect until the next rising clk.
- Write:
  - On rising clk with reset_n high, we = 1 and wa != 0: reg[wa] <= wd.
  - wa = 0: write silently discarded; reg 0 has no storage and always reads 0.
  - we = 0: no state change.
- Read:
  - Purely combinational, zero latency.
  - rdN = 0 if raN = 0, else reg[raN].
- Bypass (BYPASS = 1): if we = 1, wa != 0 and wa == raN, then rdN = wd in the same cycle, before the edge commits.
  - Both ports bypass independently; ra1 == ra2 == wa gives both ports wd.
  - BYPASS = 0: rdN shows the old value until after the edge.
- Simultaneous events:
  - Write and read of the same register in the same cycle follow the bypass rule above.
  - Reset dominates any write in the same cycle.
- Sequencing: one write per cycle; no back-pressure or handshake.
- Widths: wa/ra compared over the full ADDR_W bits; no sign or zero extension inside the block.

Optional Feature:
- Macro GRF_TRACE_EN.
- Defined: on every committed write (rising clk, reset_n high, we = 1, wa != 0), a simulation-only statement prints "@<pc 8-hex>: $<wa decimal 2-digit> <= <wd 8-hex>", one line per write, printed at the edge.
  - Writes to $0 are not printed.
- Undefined: no trace logic; RTL is fully synthesizable with identical port list (pc left unused).

Decomposition:
- Package grf_pkg:
  - constants DATA_W = 32, ADDR_W = 5, REG_ZERO = 0, REG_RA = 31;
  - typedefs reg_addr_t (ADDR_W bits) and reg_data_t (DATA_W bits).
- REG_RA is shared with the write-address select so the $31 constant has a single source.
- Sub-module grf_read_port: address decode, zero-register forcing, bypass compare and reset gating.
  - Instantiated twice (rd1, rd2).
- Storage array and write logic stay in grf_bank.

Test Plan:
- Reset: drive reset_n = 0 mid-cycle after loading $5 = 32'h1234_5678 -> rd1 (ra1 = 5) reads 0 immediately, before the next clk edge.
- Basic write/read: we = 1, wa = 8, wd = 32'hDEAD_BEEF, one edge; then we = 0, ra1 = 8, ra2 = 8 -> rd1 = rd2 = 32'hDEAD_BEEF.
- $0 protection: we = 1, wa = 0, wd = 32'hFFFF_FFFF, one edge -> ra1 = 0 gives rd1 = 0; with GRF_TRACE_EN, no trace line printed.
- Bypass (BYPASS = 1): reg9 = 32'h1; same cycle we = 1, wa = 9, wd = 32'h2, ra1 = 9 -> rd1 = 32'h2 before the edge.
  - Repeat with BYPASS = 0 -> rd1 = 32'h1 before the edge, 32'h2 after.
- jal path: we = 1, wa = 31, wd = 32'h0000_3008, pc = 32'h0000_3004 -> reg31 = 32'h0000_3008.
  - With GRF_TRACE_EN, exactly "@00003004: $31 <= 00003008" is printed.
- Full sweep: write reg[i] = i*32'h0101_0101 for i = 1..31 on consecutive edges, then read all pairs (i, 32-i) -> all values match; reg0 = 0.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared constants and types for the general register file and its write-back neighbours.
// REG_RA is the single source of the $31 link-register index used by jal.
package grf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/grf_read_port.sv
// One combinational register-file read port: decode, $0 forcing, write bypass, reset gating.
module grf_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                                  reset_n,
    input  logic [ADDR_W-1:0]                     ra,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    rf,
    input  logic                                  we,
    input  logic [ADDR_W-1:0]                     wa,
    input  logic [DATA_W-1:0]                     wd,
    output logic [DATA_W-1:0]                     rd
);
    import grf_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic byp_hit;

    // ra != 0 is checked first below, so a hit here never forwards a $0 write
    assign byp_hit = (BYPASS != 0) && we && (wa == ra);

    always_comb begin
        rd = rf[ra];
        if (!reset_n || ra == ZERO_A)
            rd = '0;
        else if (byp_hit)
            rd = wd;
    end

endmodule

// File: rtl/grf_bank.sv
// 32x32 MIPS general register file: two combinational read ports, one synchronous write port.
// Define GRF_TRACE_EN for a simulation-only per-write trace line; otherwise pc is unused.
module grf_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [31:0]       pc
);
    import grf_pkg::*;

    localparam int DEPTH    = 2**ADDR_W;
    localparam int NUM_RD   = 2;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]                 mem [1:DEPTH-1];
    logic [DEPTH-1:0][DATA_W-1:0]      rf;
    logic [NUM_RD-1:0][ADDR_W-1:0]     ra_v;
    logic [NUM_RD-1:0][DATA_W-1:0]     rd_v;

    // Entry 0 has no storage; the read ports force it to zero anyway
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++)
                if (we && wa == ADDR_W'(i))
                    mem[i] <= wd;
        end
    end

    assign rf[0] = '0;
    for (genvar g = 1; g < DEPTH; g++) begin : g_rf
        assign rf[g] = mem[g];
    end

    assign ra_v = {ra2, ra1};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        grf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_rd (
            .reset_n (reset_n),
            .ra      (ra_v[p]),
            .rf      (rf),
            .we      (we),
            .wa      (wa),
            .wd      (wd),
            .rd      (rd_v[p])
        );
    end

    assign rd1 = rd_v[0];
    assign rd2 = rd_v[1];

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (reset_n && we && wa != ZERO_A)
            $display("@%08h: $%02d <= %08h", pc, wa, wd);
    end
`else
    logic unused_pc;
    assign unused_pc = ^{pc, ZERO_A};
`endif

endmodule

// File: tb/tb_grf_bank.sv
// Scoreboarded bench for grf_bank, with one BYPASS=1 and one BYPASS=0 instance sharing stimulus.
module tb_grf_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] wd, pc;
    logic        we;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    grf_bank #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .we(we), .wa(wa), .wd(wd), .pc(pc)
    );

    grf_bank #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_n (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .we(we), .wa(wa), .wd(wd), .pc(pc)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_empty: got %08h want none", act);
        end else begin
            e = sb.pop_front();
            chk(e.tag, act, e.val);
        end
    endtask

    // Drive both read addresses, queue expectations for both instances, sample 1 time unit later
    task automatic rd_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1b, input logic [31:0] e2b,
                           input logic [31:0] e1n, input logic [31:0] e2n);
        ra1 = a1;
        ra2 = a2;
        push({tag, "_rd1_b"}, e1b);
        push({tag, "_rd2_b"}, e2b);
        push({tag, "_rd1_n"}, e1n);
        push({tag, "_rd2_n"}, e2n);
        #1;
        pop_chk(rd1_b);
        pop_chk(rd2_b);
        pop_chk(rd1_n);
        pop_chk(rd2_n);
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        @(negedge clk);
        we = 1'b1;
        wa = a;
        wd = d;
        pc = p;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    function automatic logic [31:0] sweep_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : 32'(a) * 32'h0101_0101;
    endfunction

    initial begin
        reset_n = 1'b0;
        we = 1'b0;
        ra1 = '0;
        ra2 = '0;
        wa = '0;
        wd = '0;
        pc = '0;

        #2;
        rd_pair("rst", 5'd5, 5'd8, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // async reset clears a loaded register before any clock edge
        write(5'd5, 32'h1234_5678, 32'h0);
        rd_pair("pre_rst", 5'd5, 5'd0, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        we = 1'b1;
        wa = 5'd7;
        wd = 32'hAAAA_5555;
        rd_pair("async_rst", 5'd5, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        rd_pair("post_rst", 5'd5, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0);

        write(5'd8, 32'hDEAD_BEEF, 32'h0000_1000);
        rd_pair("basic", 5'd8, 5'd8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        write(5'd0, 32'hFFFF_FFFF, 32'h0000_1004);
        rd_pair("zero", 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);

        write(5'd9, 32'h1, 32'h0000_1008);
        @(negedge clk);
        we = 1'b1;
        wa = 5'd9;
        wd = 32'h2;
        rd_pair("byp_pre", 5'd9, 5'd9, 32'h2, 32'h2, 32'h1, 32'h1);
        @(posedge clk);
        #1;
        we = 1'b0;
        rd_pair("byp_post", 5'd9, 5'd9, 32'h2, 32'h2, 32'h2, 32'h2);

        // only the matching port forwards
        @(negedge clk);
        we = 1'b1;
        wa = 5'd8;
        wd = 32'h55;
        rd_pair("byp_one", 5'd9, 5'd8, 32'h2, 32'h55, 32'h2, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        we = 1'b0;
        rd_pair("byp_one_post", 5'd9, 5'd8, 32'h2, 32'h55, 32'h2, 32'h55);

        // a $0 write in flight must not be forwarded
        @(negedge clk);
        we = 1'b1;
        wa = 5'd0;
        wd = 32'h7777_7777;
        rd_pair("byp_zero", 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;

        write(5'd31, 32'h0000_3008, 32'h0000_3004);
        rd_pair("jal", 5'd31, 5'd0, 32'h0000_3008, 32'h0, 32'h0000_3008, 32'h0);

        for (int i = 1; i < 32; i++)
            write(5'(i), sweep_val(5'(i)), 32'h0000_4000 + 32'(4 * i));
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a1, a2;
            a1 = 5'(i);
            a2 = 5'(32 - i);
            rd_pair($sformatf("sweep%0d", i), a1, a2,
                    sweep_val(a1), sweep_val(a2), sweep_val(a1), sweep_val(a2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
